// File: rtl/softmax_norm_pkg.sv
// Shared types and sizes for the softmax normalisation stage.
package softmax_pkg;

  localparam int N     = 8;
  localparam int IN_W  = 7;
  localparam int OUT_W = 8;

  localparam int IDX_W = $clog2(N);
  localparam int SUM_W = IN_W + IDX_W;
  localparam int DIV_W = IN_W + OUT_W;
  localparam int CNT_W = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {
    LOAD,
    DIV,
    EMIT,
    DONE
  } state_t;

  // A one-hot frame gives exactly 2^OUT_W, which must clip to full scale.
  function automatic logic [OUT_W-1:0] saturate(input logic [DIV_W-1:0] q);
    if (q > DIV_W'((1 << OUT_W) - 1)) return '1;
    else return q[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/softmax_norm_if.sv
// Sample input and probability output bundle of the softmax normaliser.
interface softmax_norm_if;
  import softmax_pkg::*;

  logic [IN_W-1:0]  exp_in;
  logic             exp_valid;
  logic             busy;
  logic [OUT_W-1:0] prob_out;
  logic [IDX_W-1:0] prob_idx;
  logic             prob_valid;
  logic             zero_sum;
  logic             frame_done;

  modport master (
    output exp_in, exp_valid,
    input  busy, prob_out, prob_idx, prob_valid, zero_sum, frame_done
  );

  modport slave (
    input  exp_in, exp_valid,
    output busy, prob_out, prob_idx, prob_valid, zero_sum, frame_done
  );

endinterface

// File: rtl/softmax_norm_divider.sv
// Restoring divider: the start cycle performs the first quotient bit, the
// remaining DIV_W-1 bits follow one per enabled cycle, and done rises
// exactly DIV_W enabled cycles after start. en low freezes all state.
module seq_divider
  import softmax_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic [DIV_W-1:0] quot,
  output logic             done
);

  logic [DIV_W-1:0] dvd;
  logic [SUM_W-1:0] dsr;
  logic [SUM_W-1:0] rem;
  logic [CNT_W-1:0] cnt;

  logic [SUM_W:0]   trial;
  logic [SUM_W-1:0] step_dsr;
  logic [SUM_W-1:0] rem_next;
  logic             take;

  // One restoring step, fed from the fresh operands on start.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    step_dsr = start ? divisor : dsr;
    trial    = start ? {{SUM_W{1'b0}}, dividend[DIV_W-1]} : {rem, dvd[DIV_W-1]};
    take     = trial >= {1'b0, step_dsr};
    rem_next = take ? SUM_W'(trial - {1'b0, step_dsr}) : trial[SUM_W-1:0];
  end

  // Operand load on start, then shift/subtract until the counter drains.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd  <= '0;
      dsr  <= '0;
      rem  <= '0;
      quot <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      if (start) begin
        dsr  <= divisor;
        dvd  <= {dividend[DIV_W-2:0], 1'b0};
        rem  <= rem_next;
        quot <= {{(DIV_W-1){1'b0}}, take};
        cnt  <= CNT_W'(DIV_W - 1);
        done <= 1'b0;
      end else if (cnt != '0) begin
        dvd  <= {dvd[DIV_W-2:0], 1'b0};
        rem  <= rem_next;
        quot <= {quot[DIV_W-2:0], take};
        cnt  <= cnt - CNT_W'(1);
        done <= (cnt == CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/softmax_norm.sv
// Buffers one frame of exponent values, sums them, then emits each value
// divided by the sum as a fixed-point probability, in index order.
module softmax_norm
  import softmax_pkg::*;
(
  input  logic           MHz10,
  input  logic           rst,
  input  logic           en,
  softmax_norm_if.slave  io
);

  state_t           state, state_next;
  logic [IN_W-1:0]  samples [N];
  logic [SUM_W-1:0] sum, sum_next;
  logic [IDX_W-1:0] cnt, k, idx_hold;
  logic [OUT_W-1:0] prob_hold, emit_val;
  logic             zero_sum_q;

  logic             last_accept, emit_step, emit_now, div_start, div_done;
  logic [IN_W-1:0]  next_sample;
  logic [DIV_W-1:0] dividend, quot;
  logic [SUM_W-1:0] divisor;

  // Divider launch: first sample when the frame closes, else the next index.
  always_comb begin
    last_accept = en && io.exp_valid && (state == LOAD) && (cnt == IDX_W'(N - 1));
    emit_step   = en && (state == EMIT) && (k != IDX_W'(N - 1));
    emit_now    = en && (state == EMIT);
    div_start   = last_accept || emit_step;
    sum_next    = sum + SUM_W'(io.exp_in);
    next_sample = last_accept ? samples[0] : samples[k + IDX_W'(1)];
    dividend    = {next_sample, {OUT_W{1'b0}}};
    divisor     = last_accept ? sum_next : sum;
    emit_val    = zero_sum_q ? '0 : saturate(quot);
  end

  seq_divider u_div (
    .clk      (MHz10),
    .rst      (rst),
    .en       (en),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (divisor),
    .quot     (quot),
    .done     (div_done)
  );

  // Frame sequencing; a low en holds the current state.
  always_comb begin
    state_next = state;
    if (en) begin
      unique case (state)
        LOAD: if (last_accept) state_next = DIV;
        DIV:  if (div_done) state_next = EMIT;
        EMIT: state_next = (k == IDX_W'(N - 1)) ? DONE : DIV;
        DONE: state_next = LOAD;
      endcase
    end
  end

  // State register.
  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Sample buffer, accumulator, indices and held outputs.
  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) begin
      // NOTE: the buffer is reset because a cleared frame must read back as zeros.
      for (int i = 0; i < N; i++) samples[i] <= '0;
      sum        <= '0;
      cnt        <= '0;
      k          <= '0;
      zero_sum_q <= 1'b0;
      prob_hold  <= '0;
      idx_hold   <= '0;
    end else if (en) begin
      case (state)
        LOAD: if (io.exp_valid) begin
          samples[cnt] <= io.exp_in;
          sum          <= sum_next;
          cnt          <= cnt + IDX_W'(1);
          if (cnt == IDX_W'(N - 1)) begin
            zero_sum_q <= (sum_next == '0);
            k          <= '0;
          end
        end
        EMIT: begin
          prob_hold <= emit_val;
          idx_hold  <= k;
          if (k != IDX_W'(N - 1)) k <= k + IDX_W'(1);
        end
        DONE: begin
          sum        <= '0;
          cnt        <= '0;
          zero_sum_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign io.busy       = (state != LOAD);
  assign io.prob_valid = emit_now;
  assign io.frame_done = en && (state == DONE);
  assign io.prob_out   = emit_now ? emit_val : prob_hold;
  assign io.prob_idx   = emit_now ? k : idx_hold;
  assign io.zero_sum   = zero_sum_q;

endmodule

// File: tb/tb_softmax_norm.sv
// Directed bench for softmax_norm: table of frames plus enable-stall and
// mid-frame reset sequences.
module tb_softmax_norm;
  import softmax_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;

  softmax_norm_if io ();

  softmax_norm dut (
    .MHz10 (clk),
    .rst   (rst),
    .en    (en),
    .io    (io)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0][6:0] e;
    logic [7:0][7:0] p;
    logic            zs;
  } vec_t;

  vec_t vecs [4];

  // Results captured by run_frame.
  int got_n, got_idx[8], got_out[8], got_zs[8], got_cyc[8];
  int first_cyc, last_cyc, done_cyc, done_zs, seen_done, strobe_off;
  int post_zs, post_busy, post_out, post_idx;

  task automatic run_frame(input vec_t v, input int hold_load, input int hold_div, input bit junk);
    int  sent;
    bit  off;
    sent = 0; got_n = 0; seen_done = 0; strobe_off = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1; done_zs = -1;
    for (int t = 0; t < 400 && seen_done == 0; t++) begin
      @(posedge clk); #1;
      off = (hold_load >= 0 && t >= hold_load && t < hold_load + 5) ||
            (hold_div  >= 0 && t >= hold_div  && t < hold_div  + 5);
      en = !off;
      if (sent < 8) begin
        io.exp_valid = 1'b1;
        io.exp_in    = v.e[sent];
        if (!off) begin
          if (sent == 0) first_cyc = cyc;
          if (sent == 7) last_cyc = cyc;
          sent++;
        end
      end else begin
        io.exp_valid = junk && (t % 3 == 0);
        io.exp_in    = 7'd127;
      end
      @(negedge clk);
      if (off && (io.prob_valid || io.frame_done)) strobe_off++;
      if (io.prob_valid) begin
        if (got_n < 8) begin
          got_idx[got_n] = int'(io.prob_idx);
          got_out[got_n] = int'(io.prob_out);
          got_zs[got_n]  = int'(io.zero_sum);
          got_cyc[got_n] = cyc;
        end
        got_n++;
      end
      if (io.frame_done) begin
        seen_done = 1;
        done_cyc  = cyc;
        done_zs   = int'(io.zero_sum);
      end
    end
    @(posedge clk); #1;
    io.exp_valid = 1'b0;
    en = 1'b1;
    @(negedge clk);
    post_zs   = int'(io.zero_sum);
    post_busy = int'(io.busy);
    post_out  = int'(io.prob_out);
    post_idx  = int'(io.prob_idx);
  endtask

  // hold_div_abs: absolute cycle the DIV stall starts, or -1.
  task automatic check_frame(input vec_t v, input string tag, input int n_holds, input int hold_div_abs);
    int exp_cyc;
    check({tag, " frame_done_seen"}, seen_done, 1);
    check({tag, " strobe_count"}, got_n, 8);
    for (int i = 0; i < 8 && i < got_n; i++) begin
      exp_cyc = last_cyc + 16 * (i + 1);
      if (hold_div_abs >= 0 && hold_div_abs < exp_cyc) exp_cyc += 5;
      check($sformatf("%s idx[%0d]", tag, i), got_idx[i], i);
      check($sformatf("%s prob[%0d]", tag, i), got_out[i], int'(v.p[i]));
      check($sformatf("%s zero_sum[%0d]", tag, i), got_zs[i], int'(v.zs));
      check($sformatf("%s strobe_cycle[%0d]", tag, i), got_cyc[i], exp_cyc);
    end
    check({tag, " frame_cycles"}, done_cyc - first_cyc + 1, 137 + 5 * n_holds);
    check({tag, " zero_sum_at_done"}, done_zs, int'(v.zs));
    check({tag, " strobes_while_en_low"}, strobe_off, 0);
    check({tag, " zero_sum_after"}, post_zs, 0);
    check({tag, " busy_after"}, post_busy, 0);
    check({tag, " prob_out_hold"}, post_out, int'(v.p[7]));
    check({tag, " prob_idx_hold"}, post_idx, 7);
  endtask

  initial begin
    int strobes;

    // 0: 32 x8, sum 256
    vecs[0].e = {8{7'd32}};
    vecs[0].p = {8{8'd32}};
    vecs[0].zs = 1'b0;
    // 1: one-hot at index 3
    vecs[1].e = '0;
    vecs[1].e[3] = 7'd127;
    vecs[1].p = '0;
    vecs[1].p[3] = 8'd255;
    vecs[1].zs = 1'b0;
    // 2: all zeros
    vecs[2].e = '0;
    vecs[2].p = '0;
    vecs[2].zs = 1'b1;
    // 3: 1..8, sum 36 -> floor(k*256/36)
    vecs[3].e = {7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
    vecs[3].p = {8'd56, 8'd49, 8'd42, 8'd35, 8'd28, 8'd21, 8'd14, 8'd7};
    vecs[3].zs = 1'b0;

    io.exp_valid = 1'b0;
    io.exp_in    = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset prob_out", int'(io.prob_out), 0);
    check("reset prob_idx", int'(io.prob_idx), 0);
    check("reset busy", int'(io.busy), 0);
    check("reset zero_sum", int'(io.zero_sum), 0);
    check("reset prob_valid", int'(io.prob_valid), 0);
    check("reset frame_done", int'(io.frame_done), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Table frames; the last one also pulses exp_valid while busy.
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i], -1, -1, i == 3);
      check_frame(vecs[i], $sformatf("vec%0d", i), 0, -1);
    end

    // Frame after the zero-sum frame behaves normally (already covered by
    // vec3 ordering); repeat 32 x8 for good measure.
    run_frame(vecs[0], -1, -1, 1'b0);
    check_frame(vecs[0], "after_zero", 0, -1);

    // en low 5 cycles mid-LOAD and 5 cycles inside the second divide.
    run_frame(vecs[3], 3, 40, 1'b0);
    check_frame(vecs[3], "en_stall", 2, first_cyc + 40);

    // Reset during the divide for index 4.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      io.exp_valid = 1'b1;
      io.exp_in    = vecs[3].e[i];
    end
    @(posedge clk); #1 io.exp_valid = 1'b0;
    strobes = 0;
    for (int t = 0; t < 200 && strobes < 4; t++) begin
      @(negedge clk);
      if (io.prob_valid) strobes++;
    end
    check("rst_seq strobes_before", strobes, 4);
    repeat (5) @(posedge clk);
    #1;
    check("rst_seq busy_before", int'(io.busy), 1);
    check("rst_seq prob_out_before", int'(io.prob_out), 28);
    rst = 1'b1;
    #1;
    check("rst_seq prob_out", int'(io.prob_out), 0);
    check("rst_seq prob_idx", int'(io.prob_idx), 0);
    check("rst_seq busy", int'(io.busy), 0);
    check("rst_seq zero_sum", int'(io.zero_sum), 0);
    check("rst_seq prob_valid", int'(io.prob_valid), 0);
    strobes = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (io.prob_valid || io.frame_done) strobes++;
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (io.prob_valid || io.frame_done || io.busy) strobes++;
    end
    check("rst_seq no_activity", strobes, 0);
    run_frame(vecs[0], -1, -1, 1'b0);
    check_frame(vecs[0], "after_rst", 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
